// File: rtl/frame_burst_writer.sv
// ---------------------------------------------------------------------------
// frame_burst_writer
//   Write-channel front end for one video input. Drains a pixel FIFO in the
//   mem_clk domain into SDRAM as fixed-length bursts. It walks linear
//   addresses through the frame and rotates through BUF_NUM frame buffers.
//
// Ports:
//   rst_n             async active-low reset
//   mem_clk           memory clock (only clock)
//   frame_start       one-cycle pulse, start of a new input frame
//   base_addr         address of buffer 0 (static)
//   frame_words       words per frame (static, nonzero)
//   fifo_rdusedw      words currently held in the pixel FIFO
//   fifo_rd_req       FIFO read strobe (normal-mode FIFO, data one cycle later)
//   fifo_rd_data      FIFO output data
//   wr_burst_req      burst request to the write arbiter
//   wr_burst_len      words in the current burst
//   wr_burst_addr     start address of the current burst
//   wr_burst_data_req per-word data strobe from the arbiter
//   wr_burst_data     write data (FIFO output passed straight through)
//   wr_burst_finish   one-cycle burst-complete pulse from the arbiter
//   cur_bank          frame buffer index being written
//   frame_done        one-cycle pulse when the last burst of a frame finishes
//   frame_overrun     one-cycle pulse when a frame starts before the previous
//                     frame has completed
// ---------------------------------------------------------------------------
module frame_burst_writer #(
  parameter int          MEM_DATA_BITS = 32,
  parameter logic [9:0]  BURST_LEN     = 10'd128,
  parameter int          BUF_NUM       = 3,
  parameter logic [23:0] FRAME_STRIDE  = 24'h080000
) (
  input  logic                     rst_n,
  input  logic                     mem_clk,
  input  logic                     frame_start,
  input  logic [23:0]              base_addr,
  input  logic [23:0]              frame_words,
  input  logic [10:0]              fifo_rdusedw,
  output logic                     fifo_rd_req,
  input  logic [MEM_DATA_BITS-1:0] fifo_rd_data,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [23:0]              wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic [1:0]               cur_bank,
  output logic                     frame_done,
  output logic                     frame_overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  localparam logic [1:0] LAST_BANK = 2'(BUF_NUM - 1);

  logic [1:0]  state_r;
  logic [23:0] bank_base_r;
  logic [23:0] remain_r;
  logic        pend_start_r;
  logic        first_frame_r;

  logic [1:0]  next_bank_s;
  logic [23:0] next_base_s;
  logic [9:0]  len_n_s;
  logic        fifo_ready_s;
  logic [23:0] remain_sub_s;
  logic        load_frame_s;

  // The FIFO is normal-mode, so the strobe is passed through only while a
  // burst owns the channel; the word appears one cycle later on rd_data.
  assign fifo_rd_req   = (state_r == ST_BURST) ? wr_burst_data_req : 1'b0;
  assign wr_burst_data = fifo_rd_data;

  // Next buffer selection: wrap to buffer 0 after the last one or on the
  // first frame after reset.
  always_comb begin
    next_bank_s = 2'd0;
    next_base_s = base_addr;
    if (first_frame_r || (cur_bank == LAST_BANK)) begin
      next_bank_s = 2'd0;
      next_base_s = base_addr;
    end else begin
      next_bank_s = cur_bank + 2'd1;
      next_base_s = bank_base_r + FRAME_STRIDE;
    end
  end

  // Burst length and readiness: the last burst of a frame may be short.
  always_comb begin
    len_n_s = BURST_LEN;
    if (remain_r < {14'd0, BURST_LEN}) begin
      len_n_s = remain_r[9:0];
    end else begin
      len_n_s = BURST_LEN;
    end
    fifo_ready_s = (fifo_rdusedw >= {1'b0, len_n_s});
    remain_sub_s = remain_r - {14'd0, wr_burst_len};
  end

  // A new frame is loaded from IDLE (fresh or pending start) or restarted
  // from WAIT when a start abandons the frame before its next burst.
  always_comb begin
    load_frame_s = 1'b0;
    if ((state_r == ST_IDLE) && (frame_start || pend_start_r)) begin
      load_frame_s = 1'b1;
    end else if ((state_r == ST_WAIT) && frame_start) begin
      load_frame_s = 1'b1;
    end else begin
      load_frame_s = 1'b0;
    end
  end

  // Main control FSM and registered outputs.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      bank_base_r   <= 24'd0;
      remain_r      <= 24'd0;
      pend_start_r  <= 1'b0;
      first_frame_r <= 1'b1;
      cur_bank      <= 2'd0;
      wr_burst_req  <= 1'b0;
      wr_burst_len  <= 10'd0;
      wr_burst_addr <= 24'd0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      if (load_frame_s) begin
        cur_bank      <= next_bank_s;
        bank_base_r   <= next_base_s;
        wr_burst_addr <= next_base_s;
        remain_r      <= frame_words;
        pend_start_r  <= 1'b0;
        first_frame_r <= 1'b0;
        state_r       <= ST_WAIT;
        // Restarting from WAIT throws away the rest of the old frame.
        frame_overrun <= (state_r == ST_WAIT);
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_WAIT: begin
            if (fifo_ready_s) begin
              wr_burst_len <= len_n_s;
              wr_burst_req <= 1'b1;
              state_r      <= ST_BURST;
            end else begin
              state_r <= ST_WAIT;
            end
          end
          ST_BURST: begin
            // The arbiter only samples the request in its check slot, so
            // the request stays up until the burst is reported finished.
            if (frame_start) begin
              frame_overrun <= 1'b1;
              pend_start_r  <= 1'b1;
            end else begin
              pend_start_r  <= pend_start_r;
            end
            if (wr_burst_finish) begin
              wr_burst_req  <= 1'b0;
              wr_burst_addr <= wr_burst_addr + {14'd0, wr_burst_len};
              remain_r      <= remain_sub_s;
              if (frame_start || pend_start_r) begin
                state_r <= ST_IDLE;
              end else if (remain_sub_s == 24'd0) begin
                frame_done <= 1'b1;
                state_r    <= ST_IDLE;
              end else begin
                state_r <= ST_WAIT;
              end
            end else begin
              state_r <= ST_BURST;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_frame_burst_writer
//   Directed bench for frame_burst_writer: a counting FIFO model, a simple
//   arbiter model driving data strobes and finish pulses, a table of burst
//   expectations, and hand-written hold / reset / overrun sequences.
// ---------------------------------------------------------------------------
module tb_frame_burst_writer;

  localparam int DW = 32;

  logic          rst_n;
  logic          mem_clk;
  logic          frame_start;
  logic [23:0]   base_addr;
  logic [23:0]   frame_words;
  logic [10:0]   fifo_rdusedw;
  logic          fifo_rd_req;
  logic [DW-1:0] fifo_rd_data = 32'd0;
  logic          wr_burst_req;
  logic [9:0]    wr_burst_len;
  logic [23:0]   wr_burst_addr;
  logic          wr_burst_data_req;
  logic [DW-1:0] wr_burst_data;
  logic          wr_burst_finish;
  logic [1:0]    cur_bank;
  logic          frame_done;
  logic          frame_overrun;

  int tests    = 0;
  int failed   = 0;
  int wr_total = 0;
  int rd_total = 0;
  int exp_rd   = 0;
  int done_cnt = 0;
  int ovr_cnt  = 0;
  int lvl_s;

  typedef struct {
    int          push;
    bit          start;
    int          delay;
    logic [23:0] addr;
    logic [9:0]  len;
    logic [1:0]  bank;
    int          done;
  } vec_t;

  vec_t vecs[12];

  frame_burst_writer #(
    .MEM_DATA_BITS(32),
    .BURST_LEN    (10'd128),
    .BUF_NUM      (3),
    .FRAME_STRIDE (24'h080000)
  ) dut (
    .rst_n            (rst_n),
    .mem_clk          (mem_clk),
    .frame_start      (frame_start),
    .base_addr        (base_addr),
    .frame_words      (frame_words),
    .fifo_rdusedw     (fifo_rdusedw),
    .fifo_rd_req      (fifo_rd_req),
    .fifo_rd_data     (fifo_rd_data),
    .wr_burst_req     (wr_burst_req),
    .wr_burst_len     (wr_burst_len),
    .wr_burst_addr    (wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_data    (wr_burst_data),
    .wr_burst_finish  (wr_burst_finish),
    .cur_bank         (cur_bank),
    .frame_done       (frame_done),
    .frame_overrun    (frame_overrun)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // FIFO fill level from words pushed by the bench minus words strobed out.
  always_comb begin
    lvl_s = wr_total - rd_total;
    if (lvl_s > 2047) lvl_s = 2047;
    else if (lvl_s < 0) lvl_s = 0;
    else lvl_s = lvl_s;
  end
  assign fifo_rdusedw = 11'(lvl_s);

  // Normal-mode FIFO: word N of the stream is 0xD0000000 + N, one cycle late.
  always @(posedge mem_clk) begin
    if (fifo_rd_req === 1'b1) begin
      fifo_rd_data <= 32'hD000_0000 + 32'(rd_total);
      rd_total     <= rd_total + 1;
    end
  end

  // Pulse counters for frame_done / frame_overrun.
  always @(negedge mem_clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_overrun === 1'b1) ovr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for wr_burst_req; also retires a frame_start pulse.
  task automatic wait_req(output int cycles);
    cycles = 0;
    while (wr_burst_req !== 1'b1 && cycles < 300) begin
      @(negedge mem_clk);
      frame_start = 1'b0;
      cycles++;
    end
  endtask

  // Arbiter model: hold off for 'delay' cycles, strobe e_len words, finish.
  // start_at injects a frame_start at that word; rst_at asserts reset there.
  task automatic serve(input logic [23:0] e_addr, input logic [9:0] e_len,
                       input logic [1:0] e_bank, input int delay,
                       input int start_at, input int rst_at);
    int unstable;
    int mirror;
    int data_bad;
    unstable = 0;
    mirror   = 0;
    data_bad = 0;
    check("req_up", {31'd0, wr_burst_req}, 32'd1);
    check("burst_addr", {8'd0, wr_burst_addr}, {8'd0, e_addr});
    check("burst_len", {22'd0, wr_burst_len}, {22'd0, e_len});
    check("cur_bank", {30'd0, cur_bank}, {30'd0, e_bank});
    for (int d = 0; d < delay; d++) begin
      @(negedge mem_clk);
      if (wr_burst_req !== 1'b1 || wr_burst_addr !== e_addr ||
          wr_burst_len !== e_len || fifo_rd_req !== 1'b0) unstable++;
    end
    for (int i = 0; i <= int'(e_len); i++) begin
      @(negedge mem_clk);
      frame_start = 1'b0;
      if (i > 0) begin
        if (wr_burst_data !== (32'hD000_0000 + 32'(exp_rd))) data_bad++;
        exp_rd++;
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_req", {31'd0, wr_burst_req}, 32'd0);
        check("rst_rd_req", {31'd0, fifo_rd_req}, 32'd0);
        check("rst_bank", {30'd0, cur_bank}, 32'd0);
        check("rst_data_before", data_bad, 32'd0);
        wr_burst_data_req = 1'b0;
        return;
      end
      if (i == start_at) frame_start = 1'b1;
      if (wr_burst_req !== 1'b1 || wr_burst_addr !== e_addr || wr_burst_len !== e_len) unstable++;
      wr_burst_data_req = (i < int'(e_len));
      #1;
      if (fifo_rd_req === 1'b1) mirror++;
    end
    check("burst_data", data_bad, 32'd0);
    check("rd_req_mirror", mirror, {22'd0, e_len});
    check("req_stable", unstable, 32'd0);
    @(negedge mem_clk);
    frame_start     = 1'b0;
    wr_burst_finish = 1'b1;
    @(negedge mem_clk);
    wr_burst_finish = 1'b0;
    check("req_drop", {31'd0, wr_burst_req}, 32'd0);
    #1;
  endtask

  initial begin
    int cyc;
    int d0;
    int o0;
    int stuck;

    vecs[0]  = '{300, 1'b1, 0,  24'h000000, 10'd128, 2'd0, 0};
    vecs[1]  = '{0,   1'b0, 3,  24'h000080, 10'd128, 2'd0, 0};
    vecs[2]  = '{0,   1'b0, 0,  24'h000100, 10'd44,  2'd0, 1};
    vecs[3]  = '{300, 1'b1, 40, 24'h080000, 10'd128, 2'd1, 0};
    vecs[4]  = '{0,   1'b0, 0,  24'h080080, 10'd128, 2'd1, 0};
    vecs[5]  = '{0,   1'b0, 2,  24'h080100, 10'd44,  2'd1, 1};
    vecs[6]  = '{300, 1'b1, 0,  24'h100000, 10'd128, 2'd2, 0};
    vecs[7]  = '{0,   1'b0, 0,  24'h100080, 10'd128, 2'd2, 0};
    vecs[8]  = '{0,   1'b0, 0,  24'h100100, 10'd44,  2'd2, 1};
    vecs[9]  = '{300, 1'b1, 1,  24'h000000, 10'd128, 2'd0, 0};
    vecs[10] = '{0,   1'b0, 0,  24'h000080, 10'd128, 2'd0, 0};
    vecs[11] = '{0,   1'b0, 0,  24'h000100, 10'd44,  2'd0, 1};

    rst_n             = 1'b0;
    frame_start       = 1'b0;
    base_addr         = 24'h000000;
    frame_words       = 24'd300;
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b0;

    repeat (3) @(negedge mem_clk);
    #1;
    check("reset_req", {31'd0, wr_burst_req}, 32'd0);
    check("reset_len", {22'd0, wr_burst_len}, 32'd0);
    check("reset_addr", {8'd0, wr_burst_addr}, 32'd0);
    check("reset_bank", {30'd0, cur_bank}, 32'd0);
    check("reset_done", {31'd0, frame_done}, 32'd0);
    check("reset_ovr", {31'd0, frame_overrun}, 32'd0);
    check("reset_rd_req", {31'd0, fifo_rd_req}, 32'd0);
    @(negedge mem_clk);
    rst_n = 1'b1;

    // Four complete frames: banks 0, 1, 2, 0.
    for (int k = 0; k < 12; k++) begin
      wr_total += vecs[k].push;
      if (vecs[k].start) frame_start = 1'b1;
      d0 = done_cnt;
      wait_req(cyc);
      if (vecs[k].start) check("start_latency", cyc, 32'd2);
      serve(vecs[k].addr, vecs[k].len, vecs[k].bank, vecs[k].delay, -1, -1);
      check("frame_done_pulses", done_cnt - d0, vecs[k].done);
    end
    check("no_overrun_yet", ovr_cnt, 32'd0);

    // FIFO holds only 100 words: the 128-word request must wait.
    wr_total += 100;
    frame_start = 1'b1;
    stuck = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge mem_clk);
      frame_start = 1'b0;
      if (wr_burst_req !== 1'b0) stuck++;
    end
    check("hold_no_req", stuck, 32'd0);
    wr_total += 28;
    wait_req(cyc);
    check("req_next_cycle", cyc, 32'd1);
    serve(24'h080000, 10'd128, 2'd1, 0, -1, -1);

    // Reset in the middle of burst 2.
    wr_total += 128;
    wait_req(cyc);
    serve(24'h080080, 10'd128, 2'd1, 0, -1, 50);
    check("rst_addr", {8'd0, wr_burst_addr}, 32'd0);
    check("rst_len", {22'd0, wr_burst_len}, 32'd0);
    repeat (2) @(negedge mem_clk);
    rst_n = 1'b1;

    // First frame after reset restarts in buffer 0.
    wr_total += 200;
    frame_start = 1'b1;
    wait_req(cyc);
    check("post_rst_latency", cyc, 32'd2);
    serve(24'h000000, 10'd128, 2'd0, 0, -1, -1);

    // frame_start during burst 2: overrun, burst completes, no frame_done.
    o0 = ovr_cnt;
    d0 = done_cnt;
    wait_req(cyc);
    serve(24'h000080, 10'd128, 2'd0, 0, 60, -1);
    check("overrun_pulses", ovr_cnt - o0, 32'd1);
    check("overrun_no_done", done_cnt - d0, 32'd0);
    wr_total += 200;
    wait_req(cyc);
    serve(24'h080000, 10'd128, 2'd1, 0, -1, -1);
    check("overrun_total", ovr_cnt - o0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/frame_burst_writer.md
Name: frame_burst_writer

Overview:
- Write-channel front end for one video input. Sits directly upstream of the 4-channel write arbiter; one instance drives each chN_wr_burst_* port set.
- Drains a per-channel pixel FIFO, already in the mem_clk domain, into SDRAM as fixed-length bursts.
- Walks linear addresses through the frame and rotates through BUF_NUM frame buffers.

Parameters:
- MEM_DATA_BITS, 32, width of burst data and FIFO data.
- BURST_LEN, 10'd128, maximum words per burst; range 1..1023.
- BUF_NUM, 3, number of frame buffers rotated; range 1..4.
- FRAME_STRIDE, 24'h080000, address distance between consecutive frame buffers.

Ports:
- rst_n  in  1  asynchronous active-low reset.
- mem_clk  in  1  memory clock; the only clock.
- frame_start  in  1  one-cycle pulse, synchronous to mem_clk; marks start of a new input frame.
- base_addr  in  24  address of buffer 0; static.
- frame_words  in  24  words per frame; static, must be nonzero.
- fifo_rdusedw  in  11  words currently in the pixel FIFO.
- fifo_rd_req  out  1  FIFO read strobe. FIFO is normal-mode: data appears one cycle after the strobe.
- fifo_rd_data  in  MEM_DATA_BITS  FIFO output.
- wr_burst_req  out  1  burst request to the arbiter.
- wr_burst_len  out  10  words in this burst.
- wr_burst_addr  out  24  start address of this burst.
- wr_burst_data_req  in  1  per-word data strobe from the arbiter.
- wr_burst_data  out  MEM_DATA_BITS  write data.
- wr_burst_finish  in  1  one-cycle burst-complete pulse from the arbiter.
- cur_bank  out  2  buffer index being written.
- frame_done  out  1  one-cycle pulse when the last burst of a frame finishes.
- frame_overrun  out  1  one-cycle pulse when frame_start arrives before the current frame completes.

Behaviour:
- Reset values: wr_burst_req=0, wr_burst_len=0, wr_burst_addr=0, cur_bank=0, frame_done=0, frame_overrun=0, fifo_rd_req=0, state=IDLE.
- Internal registers: bank_base (24b, reset 0), remain (24b, reset 0), pend_start (reset 0).
- wr_burst_data = fifo_rd_data, combinational.
- fifo_rd_req = wr_burst_data_req while state==BURST, else 0. This gives data valid one cycle after each strobe, as the controller expects.
- IDLE: on frame_start or pend_start:
  - if cur_bank==BUF_NUM-1 or this is the first frame after reset: cur_bank<=0, bank_base<=base_addr.
  - else: cur_bank+1, bank_base+FRAME_STRIDE.
  - Then wr_burst_addr<=new bank_base, remain<=frame_words, clear pend_start, go to WAIT.
- WAIT:
  - len_n = min(BURST_LEN, remain).
  - When fifo_rdusedw >= len_n: wr_burst_len<=len_n, wr_burst_req<=1, go to BURST.
  - wr_burst_len and wr_burst_addr stay stable from here until finish.
- BURST:
  - wr_burst_req is held high until wr_burst_finish. The arbiter samples the request only in its check slot, so the request must not drop early.
  - On wr_burst_finish: wr_burst_req<=0, wr_burst_addr+=wr_burst_len (24-bit wrap), remain-=wr_burst_len.
  - If the new remain is 0: pulse frame_done, go to IDLE. Otherwise go to WAIT.
- frame_start in WAIT: pulse frame_overrun, abandon the frame, restart bank selection exactly as in IDLE the same cycle; stay in WAIT.
- frame_start in BURST: pulse frame_overrun, set pend_start. The burst runs to finish. At finish, go to IDLE regardless of remain; frame_done does not pulse. IDLE then consumes pend_start on the next cycle.
- frame_start coincident with wr_burst_finish in BURST: treated as the BURST case above.
- frame_start in IDLE with pend_start already set: a single frame start, no overrun.
- Extra data_req after the expected word count is not checked; the arbiter is trusted.
- rst_n low mid-burst: all outputs return to reset values asynchronously; the FIFO is not flushed by this block.
- Latency: frame_start to wr_burst_req is 2 cycles minimum (IDLE->WAIT->BURST), given the FIFO holds enough words.

Test Plan:
- Reset, base_addr=0x000000, frame_words=300, BURST_LEN=128, FIFO preloaded with 300 words, one frame_start -> bursts len 128/128/44 at addr 0x000000/0x000080/0x000100; one frame_done after the third finish; cur_bank=0.
- Three more frame_starts, each frame completed -> first burst addr 0x080000, 0x100000, then 0x000000; cur_bank sequence 1, 2, 0.
- fifo_rdusedw held at 100 with len 128 pending -> wr_burst_req stays 0. Raise to 128 -> req asserts the next cycle.
- Arbiter model delays the check slot 40 cycles -> wr_burst_req, len and addr stay stable throughout; fifo_rd_req mirrors data_req exactly 128 times; wr_burst_data equals the FIFO sequence.
- frame_start injected mid-burst of burst 2 -> frame_overrun pulses once; burst 2 completes; no frame_done; next request goes to the bank-1 base at 0x080000 with len 128.
- Assert rst_n low during BURST -> wr_burst_req, fifo_rd_req and cur_bank read 0 immediately. Next frame_start -> addr 0x000000.
